melody_sequencer: RTL and testbench

- Schedules buzzer sound effects for the game.
- Arbitrates NUM_REQ effect requests (e.g. crash, coin, jump) with fixed priority.
- Fetches the granted song note-by-note from an external synchronous note ROM, then drives the tone and beat timing onto one buzzer pin.
- Sits between game-logic event pulses and the buzzer pad; it sequences and configures the tone/beat counting datapath.

---
 rtl/buzzer_pkg.sv | 29 ++
 rtl/note_timer.sv | 49 ++++
 rtl/melody_sequencer.sv | 149 ++++++++++++++
 tb/tb_melody_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and constants for the melody sequencer: FSM states, note ROM
// field layout (beats in the LSBs, tone half-period above, last flag on top).
`timescale 1ns/1ps
package buzzer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP,
    DONE
  } state_t;

  // rom_data = {last, tone_half[TONE_W-1:0], beats[BEATS_W-1:0]}
  localparam int BEATS_W   = 4;
  localparam int BEATS_LSB = 0;
  localparam int TONE_LSB  = BEATS_LSB + BEATS_W;

  localparam int DUR_W = 32;

  // Index of the lowest set bit (0 when none is set).
  function automatic int unsigned first_set(input logic [31:0] v);
    first_set = 0;
    for (int i = 31; i >= 0; i--)
      if (v[i]) first_set = i;
  endfunction

endpackage

// File: rtl/note_timer.sv
// Tone half-period divider plus note/gap duration counter. A start pulse
// reloads both; wave begins at 0 and expired is high on the final cycle.
`timescale 1ns/1ps
module note_timer
  import buzzer_pkg::*;
#(
  parameter int TONE_W = 18
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [TONE_W-1:0] tone_half,
  input  logic [DUR_W-1:0]  duration,
  output logic              wave,
  output logic              expired
);

  logic [TONE_W-1:0] half_q;
  logic [TONE_W-1:0] ph_q;
  logic [DUR_W-1:0]  dur_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      half_q <= '0;
      ph_q   <= '0;
      dur_q  <= '0;
      wave   <= 1'b0;
    end else if (start) begin
      half_q <= tone_half;
      ph_q   <= '0;
      dur_q  <= (duration == '0) ? '0 : duration - DUR_W'(1);
      wave   <= 1'b0;
    end else begin
      if (dur_q != '0) dur_q <= dur_q - DUR_W'(1);
      // half period of zero is a rest: the divider stays parked
      if (half_q != '0) begin
        if (ph_q == half_q - TONE_W'(1)) begin
          ph_q <= '0;
          wave <= ~wave;
        end else begin
          ph_q <= ph_q + TONE_W'(1);
        end
      end
    end
  end

  assign expired = (dur_q == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Fixed-priority buzzer effect sequencer: arbitrates requests, walks a song in
// the note ROM and plays it. Define MELODY_PREEMPT_EN to let higher-priority requests abort a song.
`timescale 1ns/1ps
module melody_sequencer
  import buzzer_pkg::*;
#(
  parameter int          NUM_REQ    = 3,
  parameter int          SONG_W     = 2,
  parameter int          NOTE_W     = 4,
  parameter int          TONE_W     = 18,
  parameter int unsigned BEAT_TICKS = 2500000,
  parameter int unsigned GAP_TICKS  = 250000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req,
  output logic [SONG_W+NOTE_W-1:0] rom_addr,
  input  logic [TONE_W+BEATS_W:0]  rom_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     song_done,
  output logic                     buzzer_out
);

  localparam int LAST_BIT = TONE_LSB + TONE_W;

  if ((64'(1) << SONG_W) < 64'(NUM_REQ)) begin : g_song_w_chk
    $error("SONG_W too narrow for NUM_REQ");
  end
  if (64'(BEAT_TICKS) * 64'((1 << BEATS_W) - 1) > 64'h0000_0000_FFFF_FFFF) begin : g_dur_chk
    $error("beats*BEAT_TICKS overflows the 32-bit duration counter");
  end

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  pending, clr;
  logic [SONG_W-1:0]   song_id, win;
  logic [NUM_REQ-1:0]  win_oh;
  logic [NOTE_W-1:0]   note_idx;
  logic                last_q;
  logic                take_grant, inc_note, note_over, song_end;
  logic                t_start, t_wave, t_exp;
  logic [TONE_W-1:0]   t_tone;
  logic [DUR_W-1:0]    t_dur;
  logic [BEATS_W-1:0]  rom_beats, beats_eff;

  assign win       = SONG_W'(first_set(32'(pending)));
  assign win_oh    = NUM_REQ'(1) << win;
  assign clr       = take_grant ? win_oh : '0;
  assign song_end  = last_q | (note_idx == '1);
  assign rom_beats = rom_data[BEATS_LSB +: BEATS_W];
  assign beats_eff = (rom_beats == '0) ? BEATS_W'(1) : rom_beats;

`ifdef MELODY_PREEMPT_EN
  logic hi_pend;
  // grant is one-hot, so grant-1 masks exactly the higher-priority indices
  assign hi_pend = |(pending & (grant - NUM_REQ'(1)));
`endif

  always_comb begin
    state_nxt  = state;
    take_grant = 1'b0;
    inc_note   = 1'b0;
    note_over  = 1'b0;
    t_start    = 1'b0;
    t_tone     = '0;
    t_dur      = '0;
    unique case (state)
      IDLE:  if (|pending) begin
               state_nxt  = FETCH;
               take_grant = 1'b1;
             end
      FETCH: state_nxt = LOAD;
      LOAD:  begin
               state_nxt = PLAY;
               t_start   = 1'b1;
               t_tone    = rom_data[TONE_LSB +: TONE_W];
               t_dur     = DUR_W'(beats_eff) * DUR_W'(BEAT_TICKS);
             end
      PLAY:  if (t_exp) begin
               if (GAP_TICKS != 0) begin
                 state_nxt = GAP;
                 t_start   = 1'b1;
                 t_dur     = DUR_W'(GAP_TICKS);
               end else begin
                 note_over = 1'b1;
               end
             end
      GAP:   if (t_exp) note_over = 1'b1;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (note_over) begin
      if (song_end) begin
        state_nxt = DONE;
      end else begin
        state_nxt = FETCH;
        inc_note  = 1'b1;
      end
    end
`ifdef MELODY_PREEMPT_EN
    if ((state == LOAD || state == PLAY || state == GAP) && hi_pend) begin
      state_nxt  = FETCH;
      take_grant = 1'b1;
      inc_note   = 1'b0;
      t_start    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      pending  <= '0;
      grant    <= '0;
      song_id  <= '0;
      note_idx <= '0;
      last_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      // a request landing on its own clear cycle keeps the bit set
      pending <= req | (pending & ~clr);
      if (take_grant) begin
        grant    <= win_oh;
        song_id  <= win;
        note_idx <= '0;
      end else if (inc_note) begin
        note_idx <= note_idx + NOTE_W'(1);
      end
      if (state == LOAD) last_q <= rom_data[LAST_BIT];
      if (state == DONE) grant <= '0;
    end
  end

  note_timer #(.TONE_W(TONE_W)) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .start     (t_start),
    .tone_half (t_tone),
    .duration  (t_dur),
    .wave      (t_wave),
    .expired   (t_exp)
  );

  assign rom_addr   = {song_id, note_idx};
  assign busy       = (state != IDLE);
  assign song_done  = (state == DONE);
  assign buzzer_out = t_wave & (state == PLAY);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed + randomized bench for melody_sequencer; a per-cycle output trace
// is derived from the ROM contents and the note/beat/gap timing rules.
`timescale 1ns/1ps
module tb_melody_sequencer;

  localparam int NUM_REQ = 3;
  localparam int SONG_W  = 2;
  localparam int NOTE_W  = 4;
  localparam int TONE_W  = 18;
  localparam int BT      = 8;
  localparam int GT      = 2;
  localparam int AW      = SONG_W + NOTE_W;
  localparam int DW      = 1 + TONE_W + 4;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic [AW-1:0]      rom_addr;
  logic [DW-1:0]      rom_data = '0;
  logic [NUM_REQ-1:0] grant;
  logic               busy, song_done, buzzer_out;

  logic [DW-1:0] rom [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  int         addr_q[$];

  melody_sequencer #(
    .NUM_REQ(NUM_REQ), .SONG_W(SONG_W), .NOTE_W(NOTE_W), .TONE_W(TONE_W),
    .BEAT_TICKS(BT), .GAP_TICKS(GT)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .rom_addr(rom_addr), .rom_data(rom_data),
    .grant(grant), .busy(busy), .song_done(song_done), .buzzer_out(buzzer_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [5:0] outs();
    return {grant, busy, song_done, buzzer_out};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected per-cycle {grant,busy,song_done,buzzer} from the first FETCH to DONE.
  task automatic build(input int song);
    logic [2:0] g;
    exp_q.delete();
    addr_q.delete();
    g = 3'(1 << song);
    for (int n = 0; n < 16; n++) begin
      logic [DW-1:0] e;
      int th, b, d;
      e  = rom[song*16 + n];
      th = int'(e[21:4]);
      b  = int'(e[3:0]);
      d  = ((b == 0) ? 1 : b) * BT;
      exp_q.push_back({g, 3'b100}); addr_q.push_back(song*16 + n);
      exp_q.push_back({g, 3'b100}); addr_q.push_back(-1);
      for (int k = 0; k < d; k++) begin
        exp_q.push_back({g, 2'b10, (th != 0) && ((k / th) % 2 == 1)});
        addr_q.push_back(-1);
      end
      for (int k = 0; k < GT; k++) begin
        exp_q.push_back({g, 3'b100}); addr_q.push_back(-1);
      end
      if (e[22]) break;
    end
    exp_q.push_back({g, 3'b110}); addr_q.push_back(-1);
  endtask

  // Called on the negedge of the song's first FETCH cycle.
  task automatic play(input int song, input int inj_k, input logic [2:0] inj_mask, input int nmax);
    build(song);
    for (int k = 0; k < exp_q.size() && k < nmax; k++) begin
      check($sformatf("song%0d_cyc%0d", song, k), 32'(outs()), 32'(exp_q[k]));
      if (addr_q[k] >= 0) check($sformatf("rom_addr_s%0d_cyc%0d", song, k), 32'(rom_addr), 32'(addr_q[k]));
      if (k == inj_k) req = inj_mask;
      @(negedge clk);
      if (k == inj_k) req = '0;
    end
  endtask

  task automatic kick(input logic [2:0] mask);
    @(negedge clk);
    req = mask;
    @(negedge clk);
    req = '0;
    check("idle_before_start", 32'(outs()), 32'(0));
    @(negedge clk);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(outs()), 32'(0));
      @(negedge clk);
    end
  endtask

  task automatic fill_rand();
    for (int s = 0; s < 4; s++) begin
      int len;
      len = $urandom_range(1, 4);
      for (int n = 0; n < 16; n++)
        rom[s*16 + n] = {(n == len - 1), 18'($urandom_range(0, 5)), 4'($urandom_range(0, 3))};
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("reset_outs", 32'(outs()), 32'(0));
    check("reset_addr", 32'(rom_addr), 32'(0));
    rstn = 1'b1;
    idle(100, "idle_no_req");

    // single song from the worked example
    rom[16] = {1'b0, 18'd3, 4'd1};
    rom[17] = {1'b1, 18'd0, 4'd2};
    kick(3'b010);
    play(1, -1, 3'b000, 1000);
    idle(3, "after_single");

    // random single requests
    for (int it = 0; it < 6; it++) begin
      int s;
      fill_rand();
      s = $urandom_range(0, 2);
      kick(3'(1 << s));
      play(s, -1, 3'b000, 4000);
      idle(2, "after_random");
    end

    // simultaneous requests: priority order, one IDLE cycle between songs
    fill_rand();
    kick(3'b110);
    play(1, -1, 3'b000, 4000);
    idle(1, "between_songs");
    play(2, -1, 3'b000, 4000);
    idle(2, "after_pair");

    // repeat request while the same song plays
    fill_rand();
    kick(3'b010);
    play(1, 6, 3'b010, 4000);
    idle(1, "before_replay");
    play(1, -1, 3'b000, 4000);
    idle(2, "after_replay");

    // wrap guard: no last flag anywhere in song 2
    for (int n = 0; n < 16; n++) begin
      rom[32 + n] = {1'b0, 18'($urandom_range(0, 3)), 4'($urandom_range(0, 1))};
      rom[48 + n] = {1'b1, 18'd1, 4'd1};
    end
    kick(3'b100);
    play(2, -1, 3'b000, 4000);
    idle(2, "after_wrap");

    // mid-play reset
    fill_rand();
    rom[0][3:0] = 4'd2;
    kick(3'b001);
    play(0, -1, 3'b000, 5);
    #2 rstn = 1'b0;
    #1 check("reset_mid_play", 32'(outs()), 32'(0));
    @(negedge clk);
    idle(3, "held_in_reset");
    rstn = 1'b1;
    idle(10, "after_mid_reset");

    // higher-priority request during song 2
    fill_rand();
    rom[32][3:0] = 4'd2;
    kick(3'b100);
`ifdef MELODY_PREEMPT_EN
    play(2, 5, 3'b001, 6);
    begin
      int w;
      w = 0;
      while (grant !== 3'b001 && w < 2) begin
        check("no_done_on_abort", 32'(song_done), 32'(0));
        @(negedge clk);
        w++;
      end
    end
    check("preempt_grant", 32'(grant), 32'(3'b001));
    play(0, -1, 3'b000, 4000);
    idle(2, "after_preempt");
`else
    play(2, 5, 3'b001, 4000);
    idle(1, "before_waiting_song");
    play(0, -1, 3'b000, 4000);
    idle(2, "after_waiting_song");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
